// File: rtl/cordic_engine.sv
// Iterative CORDIC: sin/cos (rotation) or atan2/magnitude (vectoring), UNROLL micro-rotations per clk_en cycle.
// Vectoring mode and the x_in/y_in operand path exist only when CORDIC_VECTOR_EN is defined.
module cordic_engine #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER   = 20,
  parameter int UNROLL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int STEPS = ITER / UNROLL;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Angle constants are held at Q30 and rounded down to FRAC (FRAC <= 30).
  localparam logic [63:0] PI_Q30 = 64'hC90FDAA2;
  localparam logic [63:0] K64    = (64'd6072529 * (64'd1 << FRAC) + 64'd5000000) / 64'd10000000;

  function automatic logic [63:0] round_q30(input logic [63:0] v, input int shift);
    if (shift <= 0) return v;
    return (v + (64'd1 << (shift - 1))) >> shift;
  endfunction

  localparam logic signed [WIDTH-1:0] PI      = WIDTH'(round_q30(PI_Q30, 30 - FRAC));
  localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(round_q30(PI_Q30, 31 - FRAC));
  localparam logic signed [WIDTH-1:0] K_INIT  = WIDTH'(K64);

  function automatic logic signed [WIDTH-1:0] atan_tab(input int i);
    logic [63:0] t;
    case (i)
      0:  t = 64'h3243F6A8;
      1:  t = 64'h1DAC6705;
      2:  t = 64'h0FADBAFC;
      3:  t = 64'h07F56EA6;
      4:  t = 64'h03FEAB76;
      5:  t = 64'h01FFD55B;
      6:  t = 64'h00FFFAAA;
      7:  t = 64'h007FFF55;
      8:  t = 64'h003FFFEA;
      9:  t = 64'h001FFFFD;
      10: t = 64'h000FFFFF;
      11: t = 64'h0007FFFF;
      12: t = 64'h0003FFFF;
      13: t = 64'h0001FFFF;
      14: t = 64'h0000FFFF;
      15: t = 64'h00007FFF;
      16: t = 64'h00003FFF;
      17: t = 64'h00001FFF;
      18: t = 64'h00000FFF;
      19: t = 64'h000007FF;
      20: t = 64'h000003FF;
      21: t = 64'h000001FF;
      22: t = 64'h000000FF;
      23: t = 64'h0000007F;
      default: t = 64'h0;
    endcase
    return WIDTH'(round_q30(t, 30 - FRAC));
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nx;
  logic                    accept, last;
  logic [CW-1:0]           cnt;
  logic                    mode_r, neg_r;
  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic signed [WIDTH-1:0] x0, y0, z0;
  logic                    mode0, neg0;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (clk_en && in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (clk_en && cnt == CW'(STEPS - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (clk_en && out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Fold the angle into [-pi/2, pi/2]; cos changes sign, sin does not.
  always_comb begin
    mode0 = 1'b0;
    neg0  = 1'b0;
    x0    = K_INIT;
    y0    = '0;
    z0    = z_in;
    if (z_in > HALF_PI) begin
      z0   = PI - z_in;
      neg0 = 1'b1;
    end else if (z_in < -HALF_PI) begin
      z0   = -PI - z_in;
      neg0 = 1'b1;
    end
`ifdef CORDIC_VECTOR_EN
    if (mode) begin
      mode0 = 1'b1;
      neg0  = 1'b0;
      if (x_in[WIDTH-1]) begin
        x0 = -x_in;
        y0 = -y_in;
        z0 = y_in[WIDTH-1] ? -PI : PI;
      end else begin
        x0 = x_in;
        y0 = y_in;
        z0 = '0;
      end
    end
`endif
  end

`ifndef CORDIC_VECTOR_EN
  logic unused_vec_ops;
  assign unused_vec_ops = ^{mode, x_in, y_in};
`endif

  always_comb begin : chain
    logic signed [WIDTH-1:0] xc, yc, zc, xt;
    logic                    dpos;
    int                      idx;
    xc   = x_r;
    yc   = y_r;
    zc   = z_r;
    xt   = '0;
    dpos = 1'b0;
    idx  = 0;
    for (int u = 0; u < UNROLL; u++) begin
      idx  = int'(cnt) * UNROLL + u;
      // d = +1: rotation when z >= 0, vectoring when y < 0
      dpos = mode_r ? yc[WIDTH-1] : ~zc[WIDTH-1];
      xt   = xc;
      if (dpos) begin
        xc = xc - (yc >>> idx);
        yc = yc + (xt >>> idx);
        zc = zc - atan_tab(idx);
      end else begin
        xc = xc + (yc >>> idx);
        yc = yc - (xt >>> idx);
        zc = zc + atan_tab(idx);
      end
    end
    x_nx = xc;
    y_nx = yc;
    z_nx = zc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mode_r <= 1'b0;
      neg_r  <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mode_r <= mode0;
      neg_r  <= neg0;
      x_r    <= x0;
      y_r    <= y0;
      z_r    <= z0;
    end else if (state == RUN && clk_en) begin
      cnt <= cnt + 1'b1;
      x_r <= x_nx;
      y_r <= y_nx;
      z_r <= z_nx;
      if (last) begin
        x_out <= neg_r ? -x_nx : x_nx;
        y_out <= y_nx;
        z_out <= z_nx;
      end
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed self-checking bench for cordic_engine at default parameters (Q4.23, 20 iterations, 2 per cycle).
module tb_cordic_engine;

  logic        clk = 1'b0;
  logic        rst, clk_en, in_valid, in_ready, mode, out_valid, out_ready;
  logic [26:0] x_in, y_in, z_in, x_out, y_out, z_out;

  int tests_run = 0;
  int failures  = 0;

  cordic_engine dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  // Stimulus only: present one request and let it be taken on the next edge.
  task automatic start_op(input logic m, input logic [26:0] xi, input logic [26:0] yi, input logic [26:0] zi);
    @(negedge clk);
    mode = m; x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if ({x_out, y_out, z_out} !== 81'd0) begin
      failures++; $display("FAIL reset_outputs got %h %h %h want 0 0 0", x_out, y_out, z_out);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_quiet got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rotation_zero();
    int n, ex, ey;
    start_op(1'b0, '0, '0, 27'd0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 10) begin failures++; $display("FAIL rot0_latency got %0d want 10", n); end
    ex = $signed(x_out) - 8388608;
    ey = $signed(y_out);
    tests_run++;
    if (ex > 64 || ex < -64) begin failures++; $display("FAIL rot0_cos got %0d want 8388608 +-64", $signed(x_out)); end
    tests_run++;
    if (ey > 64 || ey < -64) begin failures++; $display("FAIL rot0_sin got %0d want 0 +-64", $signed(y_out)); end
    release_result();
  endtask

  // 2.5 rad folds above pi/2; out_ready held high throughout RUN.
  task automatic test_rotation_fold();
    int n, ex, ey;
    out_ready = 1'b1;
    start_op(1'b0, '0, '0, 27'h1400000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 10) begin failures++; $display("FAIL fold_latency got %0d want 10", n); end
    ex = $signed(x_out) + 6720479;
    ey = $signed(y_out) - 5020296;
    tests_run++;
    if (ex > 64 || ex < -64) begin failures++; $display("FAIL fold_cos got %0d want -6720479 +-64", $signed(x_out)); end
    tests_run++;
    if (ey > 64 || ey < -64) begin failures++; $display("FAIL fold_sin got %0d want 5020296 +-64", $signed(y_out)); end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL fold_early_ready got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

`ifdef CORDIC_VECTOR_EN
  task automatic test_vectoring();
    int n, ex, ey, ez;
    start_op(1'b1, -27'sh0800000, 27'h0800000, 27'h1234567);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 10) begin failures++; $display("FAIL vec_latency got %0d want 10", n); end
    ez = $signed(z_out) - 19765192;
    ex = $signed(x_out) - 19535987;
    ey = $signed(y_out);
    tests_run++;
    if (ez > 64 || ez < -64) begin failures++; $display("FAIL vec_atan2 got %0d want 19765192 +-64", $signed(z_out)); end
    tests_run++;
    if (ex > 64 || ex < -64) begin failures++; $display("FAIL vec_mag got %0d want 19535987 +-64", $signed(x_out)); end
    tests_run++;
    if (ey > 64 || ey < -64) begin failures++; $display("FAIL vec_resid got %0d want 0 +-64", $signed(y_out)); end
    release_result();
  endtask
`else
  task automatic test_mode_ignored();
    int n, ex, ey;
    start_op(1'b1, 27'h0123456, 27'h7ABCDEF, 27'd0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    tests_run++;
    if (n !== 10) begin failures++; $display("FAIL modeign_latency got %0d want 10", n); end
    ex = $signed(x_out) - 8388608;
    ey = $signed(y_out);
    tests_run++;
    if (ex > 64 || ex < -64) begin failures++; $display("FAIL modeign_cos got %0d want 8388608 +-64", $signed(x_out)); end
    tests_run++;
    if (ey > 64 || ey < -64) begin failures++; $display("FAIL modeign_sin got %0d want 0 +-64", $signed(y_out)); end
    release_result();
  endtask
`endif

  // -2.5 rad folds below -pi/2; result is held under backpressure.
  task automatic test_backpressure();
    int n, ex, ey;
    logic [26:0] hx, hy;
    start_op(1'b0, '0, '0, -27'sh1400000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    hx = x_out; hy = y_out;
    in_valid = 1'b1; z_in = 27'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ex = $signed(x_out) + 6720479;
      ey = $signed(y_out) + 5020296;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold_%0d got out_valid=%b in_ready=%b want 1 0", c, out_valid, in_ready);
      end
      tests_run++;
      if (ex > 64 || ex < -64 || ey > 64 || ey < -64 || x_out !== hx || y_out !== hy) begin
        failures++; $display("FAIL bp_value_%0d got %0d %0d want -6720479 -5020296 +-64, stable", c, $signed(x_out), $signed(y_out));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_release_same got in_ready=%b want 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release_next got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    ex = $signed(x_out) + 6720479;
    tests_run++;
    if (ex > 64 || ex < -64) begin failures++; $display("FAIL bp_keep got %0d want -6720479 +-64", $signed(x_out)); end
  endtask

  task automatic test_clk_en();
    int c, en_cnt, ex, ey;
    start_op(1'b0, '0, '0, 27'h1400000);
    c = 0; en_cnt = 0;
    @(negedge clk);
    while (!out_valid && c < 60) begin
      clk_en = (c % 3 == 2);
      if (clk_en) en_cnt++;
      c++;
      @(negedge clk);
    end
    tests_run++;
    if (out_valid !== 1'b1 || en_cnt !== 10) begin
      failures++; $display("FAIL clken_latency got %0d enabled edges (out_valid=%b) want 10", en_cnt, out_valid);
    end
    ex = $signed(x_out) + 6720479;
    ey = $signed(y_out) - 5020296;
    tests_run++;
    if (ex > 64 || ex < -64 || ey > 64 || ey < -64) begin
      failures++; $display("FAIL clken_value got %0d %0d want -6720479 5020296 +-64", $signed(x_out), $signed(y_out));
    end
    clk_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL clken_frozen got out_valid=%b want 1", out_valid); end
    clk_en = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL clken_resume got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_rst_mid_run();
    int pulses, n, ex, ey;
    start_op(1'b0, '0, '0, 27'h0800000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_state got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tests_run++;
    if ({x_out, y_out, z_out} !== 81'd0) begin
      failures++; $display("FAIL rst_outputs got %h %h %h want 0 0 0", x_out, y_out, z_out);
    end
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin failures++; $display("FAIL rst_no_pulse got %0d want 0", pulses); end
    start_op(1'b0, '0, '0, 27'h0800000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    ex = $signed(x_out) - 4532384;
    ey = $signed(y_out) - 7058770;
    tests_run++;
    if (n !== 10 || ex > 64 || ex < -64 || ey > 64 || ey < -64) begin
      failures++; $display("FAIL rst_recover got lat=%0d %0d %0d want 10 4532384 7058770 +-64", n, $signed(x_out), $signed(y_out));
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_rotation_zero();
    test_rotation_fold();
`ifdef CORDIC_VECTOR_EN
    test_vectoring();
`else
    test_mode_ignored();
`endif
    test_backpressure();
    test_clk_en();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
# cordic_engine

Parametrised iterative CORDIC engine, the successor to the single-mode cosine/sine unit. It computes sin and cos together in rotation mode, or atan2 and magnitude in vectoring mode. Width, iteration count and iterations-per-cycle are parameters. It uses a valid/ready handshake on both sides and sits behind the peripheral register interface, gated by the shared clk_en.

## Interface
Parameters:
- WIDTH, 27: signed data width for x/y/z.
- FRAC, 23: fractional bits (Q(WIDTH-FRAC).FRAC, radians for angles).
- ITER, 20: total micro-rotations; range 4..24; must be a multiple of UNROLL.
- UNROLL, 2: micro-rotations chained combinationally per clock; range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- clk_en  in  1  global enable; all state and handshakes advance only when high.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- mode  in  1  0 = rotation, 1 = vectoring; sampled on accept.
- x_in, y_in  in  WIDTH  signed vectoring operands; ignored in rotation.
- z_in  in  WIDTH  signed angle in rotation; ignored in vectoring.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- x_out  out  WIDTH  rotation: cos; vectoring: magnitude × A.
- y_out  out  WIDTH  rotation: sin; vectoring: residual (≈0).
- z_out  out  WIDTH  rotation: residual angle; vectoring: atan2(y_in, x_in).

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE and zeroes x_out/y_out/z_out, the count and the internal registers.
- IDLE→RUN on in_valid & in_ready & clk_en. The pre-rotated operands and mode are registered on that edge.
- Rotation pre-rotation: x0 = 1/A (K = round(0.6072529·2^FRAC)), y0 = 0.
  - If z_in > π/2: z0 = π − z_in, negate flag set.
  - If z_in < −π/2: z0 = −π − z_in, negate flag set.
  - Otherwise z0 = z_in.
  - The negate flag negates x_out only (cos); sin is unchanged.
- Vectoring pre-rotation:
  - If x_in < 0: x0 = −x_in, y0 = −y_in, and z0 = +π when y_in ≥ 0, else −π.
  - Otherwise x0 = x_in, y0 = y_in, z0 = 0.
- Micro-rotation i, with d = sign(z) in rotation or −sign(y) in vectoring (zero counts as positive):
  - x −= d·(y>>>i)
  - y += d·(x>>>i)
  - z −= d·atan(2^−i)
- Shift and table rules:
  - Shifts are arithmetic (truncation toward −∞).
  - The atan table holds round(atan(2^−i)·2^FRAC) for i = 0..ITER−1.
  - π and π/2 are rounded at FRAC.
- RUN performs UNROLL iterations per enabled cycle for ITER/UNROLL cycles. The last cycle writes the outputs and moves to DONE.
- DONE holds the outputs stable. On out_ready & clk_en it moves to IDLE; the outputs keep their last values.
- Input ranges:
  - Rotation |z_in| ≤ π.
  - Vectoring |x_in|, |y_in| ≤ 2^(WIDTH−FRAC−1)/2.5, which keeps A·√2·|v| in range.
  - Outside these ranges the numeric results are unspecified, but the handshake still completes in normal latency.
- Accuracy: error ≤ 64 LSB at the defaults.

## Timing
- Accept edge k. out_valid is high after edge k + ITER/UNROLL (10 cycles at the defaults), counting enabled cycles only.
- in_ready is low from the accept edge until the edge after the output handshake. Minimum spacing between accepts is ITER/UNROLL + 2 cycles.
- out_valid and in_ready are decoded from state only, never combinationally from in_valid/out_ready.
- With clk_en low, everything is frozen: no transfer occurs even if valid and ready are both high.
- rst wins over every other event. Reset mid-RUN or in DONE aborts the operation and drops out_valid the next cycle, with no stale result.
- out_ready held high in RUN has no effect until DONE.

## Configuration
- CORDIC_VECTOR_EN defined: vectoring mode, the x_in/y_in operand path and the vectoring pre-rotation are compiled in.
- CORDIC_VECTOR_EN undefined: mode is ignored and always treated as rotation; x_in/y_in are unused. Behaviour and latency in rotation mode are identical.

## Test plan
- Reset, then idle: out_valid = 0, in_ready = 1, x_out = y_out = z_out = 0; in_valid held low produces no activity.
- Rotation with z_in = 0: x_out ≈ 0x0800000 and y_out ≈ 0 within 64 LSB; out_valid rises exactly 10 cycles after accept.
- Rotation with z_in = 0x1400000 (2.5 rad): x_out ≈ −0x0668BDF and y_out ≈ 0x04C9A88 within 64 LSB, exercising the >π/2 fold.
- Vectoring with x_in = −0x0800000, y_in = 0x0800000: z_out ≈ 0x12D97C7 (3π/4) and x_out ≈ 2.3289·2^23 within 64 LSB.
- out_ready low for 5 cycles in DONE:
  - outputs stay stable and out_valid stays high;
  - a concurrent in_valid is not accepted;
  - then out_ready high gives in_ready = 1 one cycle later.
- Robustness:
  - clk_en toggled 1-of-3 during RUN: latency stretches to 10 enabled cycles and results are identical.
  - rst asserted mid-RUN: back to IDLE, no out_valid pulse.
